sprite_frame_buffer: RTL and testbench

//  Double-buffered 256x256 RGB frame buffer at the sink end of the sprite pixel-write interface.
//  - Accepts pixel writes (fb_wfb) into the back buffer.
//  - Accepts a draw request (fb_dfb) that swaps front/back buffers at the next vertical sync.
//  - Serves pixel reads from the front buffer to the display scan-out logic.
//  - Drives fb_busy back to the sprite command controller while a swap or clear is pending.

---
 rtl/sprite_fb_pkg.sv | 27 ++
 rtl/sprite_frame_buffer_bank.sv | 46 ++++
 rtl/sprite_frame_buffer.sv | 163 ++++++++++++++++
 tb/tb_sprite_frame_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_fb_pkg
//  Description : Shared types for the sprite frame buffer: the controller
//                state encoding, the frame size and the packed RGB pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
package sprite_fb_pkg;

    localparam int FB_PIXELS = 65536;
    localparam int COLOR_W   = 8;

    // CLEAR is only reachable when FB_AUTOCLEAR_EN is defined.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SWAP_PEND = 2'd1,
        CLEAR     = 2'd2
    } fb_state_t;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

endpackage
`default_nettype wire

// File: rtl/sprite_frame_buffer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : fb_bank
//  Description : Simple dual-port RAM, one write port and one registered
//                read port with single-cycle latency. Contents are not reset;
//                only the read data register is cleared by rst.
//  Ports       : clk, rst      - clock / synchronous active-high reset
//                we/waddr/wdata - write port
//                re/raddr       - read strobe and address
//                rdata          - read data, valid the cycle after re
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_bank #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] r_mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read register holds its value between strobes so the display side
    // sees the last fetched pixel when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_frame_buffer
//  Description : Double-buffered square RGB frame buffer. Sprite writes land
//                in the back bank, display reads come from the front bank,
//                and a draw request swaps the banks at the next vsync.
//                Optional macro FB_AUTOCLEAR_EN zero-fills the new back bank
//                after every swap (one pixel per cycle, busy throughout).
//  Ports       : clk, rst                  - clock / sync active-high reset
//                fb_wfb, fb_px, fb_r/g/b   - pixel write into back bank
//                fb_dfb                    - swap request pulse
//                fb_busy                   - swap/clear pending, input dropped
//                disp_req, disp_px         - display read strobe / address
//                disp_vsync                - start of vertical blanking
//                disp_valid, disp_r/g/b    - front-bank read data
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_frame_buffer
    import sprite_fb_pkg::*;
#(
    parameter int COORD_BITS = 8,
    parameter int COLOR_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fb_wfb,
    input  logic                    fb_dfb,
    input  logic [2*COORD_BITS-1:0] fb_px,
    input  logic [COLOR_BITS-1:0]   fb_r,
    input  logic [COLOR_BITS-1:0]   fb_g,
    input  logic [COLOR_BITS-1:0]   fb_b,
    output logic                    fb_busy,
    input  logic                    disp_req,
    input  logic [2*COORD_BITS-1:0] disp_px,
    input  logic                    disp_vsync,
    output logic                    disp_valid,
    output logic [COLOR_BITS-1:0]   disp_r,
    output logic [COLOR_BITS-1:0]   disp_g,
    output logic [COLOR_BITS-1:0]   disp_b
);

    localparam int ADDR_BITS = 2 * COORD_BITS;
    localparam int DATA_BITS = 3 * COLOR_BITS;

    fb_state_t             r_state;
    logic                  r_front_sel;
    logic                  r_busy;
    logic                  r_valid;
    logic                  r_rd_sel;

    logic                  w_wr_ok;
    logic                  w_dfb_ok;
    logic                  w_clr_we;
    logic                  w_back_we;
    logic [ADDR_BITS-1:0]  w_waddr;
    logic [DATA_BITS-1:0]  w_wdata;
    logic [DATA_BITS-1:0]  w_rd0;
    logic [DATA_BITS-1:0]  w_rd1;

`ifdef FB_AUTOCLEAR_EN
    logic [ADDR_BITS-1:0]  r_clr_addr;
`endif

    // Inputs are accepted only when the registered busy flag is low; busy
    // lingers one cycle after the state returns to IDLE.
    assign w_wr_ok  = fb_wfb && !r_busy && (r_state == IDLE);
    assign w_dfb_ok = fb_dfb && !r_busy && (r_state == IDLE);

`ifdef FB_AUTOCLEAR_EN
    assign w_clr_we = (r_state == CLEAR);
    assign w_waddr  = w_clr_we ? r_clr_addr : fb_px;
    assign w_wdata  = w_clr_we ? '0 : {fb_r, fb_g, fb_b};
`else
    assign w_clr_we = 1'b0;
    assign w_waddr  = fb_px;
    assign w_wdata  = {fb_r, fb_g, fb_b};
`endif

    assign w_back_we = w_wr_ok || w_clr_we;

    // Back bank is the one not selected as front.
    fb_bank #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    (w_back_we && r_front_sel),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .re    (disp_req),
        .raddr (disp_px),
        .rdata (w_rd0)
    );

    fb_bank #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    (w_back_we && !r_front_sel),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .re    (disp_req),
        .raddr (disp_px),
        .rdata (w_rd1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_front_sel <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_rd_sel    <= 1'b0;
`ifdef FB_AUTOCLEAR_EN
            r_clr_addr  <= '0;
`endif
        end else begin
            // The bank choice is latched with the request, so a read issued
            // in the swap cycle still returns the old front bank.
            r_valid <= disp_req;
            if (disp_req) begin
                r_rd_sel <= r_front_sel;
            end

            case (r_state)
                IDLE: begin
                    r_busy <= w_dfb_ok;
                    if (w_dfb_ok) begin
                        r_state <= SWAP_PEND;
                    end
                end
                SWAP_PEND: begin
                    r_busy <= 1'b1;
                    if (disp_vsync) begin
                        r_front_sel <= ~r_front_sel;
`ifdef FB_AUTOCLEAR_EN
                        r_clr_addr  <= '0;
                        r_state     <= CLEAR;
`else
                        r_state     <= IDLE;
`endif
                    end
                end
`ifdef FB_AUTOCLEAR_EN
                CLEAR: begin
                    r_busy     <= 1'b1;
                    r_clr_addr <= r_clr_addr + ADDR_BITS'(1);
                    if (r_clr_addr == {ADDR_BITS{1'b1}}) begin
                        r_state <= IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fb_busy    = r_busy;
    assign disp_valid = r_valid;
    assign {disp_r, disp_g, disp_b} = r_rd_sel ? w_rd1 : w_rd0;

endmodule
`default_nettype wire

// File: tb/tb_sprite_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_frame_buffer
//  Description : Directed bench for sprite_frame_buffer. A cycle table covers
//                writes, swaps, dropped input while busy, vsync coinciding
//                with the request, reset mid-swap and address wrap. With
//                FB_AUTOCLEAR_EN defined a hand sequence covers the clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_frame_buffer;
    import sprite_fb_pkg::*;

    logic        clk = 1'b0;
    logic        rst, fb_wfb, fb_dfb, disp_req, disp_vsync;
    logic [15:0] fb_px, disp_px;
    logic [7:0]  fb_r, fb_g, fb_b;
    logic        fb_busy, disp_valid;
    logic [7:0]  disp_r, disp_g, disp_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sprite_frame_buffer #(.COORD_BITS(8), .COLOR_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .fb_wfb     (fb_wfb),
        .fb_dfb     (fb_dfb),
        .fb_px      (fb_px),
        .fb_r       (fb_r),
        .fb_g       (fb_g),
        .fb_b       (fb_b),
        .fb_busy    (fb_busy),
        .disp_req   (disp_req),
        .disp_px    (disp_px),
        .disp_vsync (disp_vsync),
        .disp_valid (disp_valid),
        .disp_r     (disp_r),
        .disp_g     (disp_g),
        .disp_b     (disp_b)
    );

    // One row = inputs for one cycle, and the registered outputs expected
    // just after the edge that ends that cycle.
    typedef struct {
        logic        rst, wfb, dfb;
        logic [15:0] px;
        rgb_t        col;
        logic        vsync, req;
        logic [15:0] rpx;
        logic        e_busy, e_valid, chk;
        rgb_t        e_data;
    } vec_t;

    function automatic vec_t mk(input logic r, w, d, input logic [15:0] p,
                                input logic [23:0] c, input logic vs, rq,
                                input logic [15:0] rp, input logic eb, ev, ck,
                                input logic [23:0] ed);
        vec_t v;
        v.rst = r; v.wfb = w; v.dfb = d; v.px = p; v.col = c;
        v.vsync = vs; v.req = rq; v.rpx = rp;
        v.e_busy = eb; v.e_valid = ev; v.chk = ck; v.e_data = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; fb_wfb = v.wfb; fb_dfb = v.dfb; fb_px = v.px;
        {fb_r, fb_g, fb_b} = v.col;
        disp_vsync = v.vsync; disp_req = v.req; disp_px = v.rpx;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] rgb_out();
        return {disp_r, disp_g, disp_b};
    endfunction

    vec_t idle_v;
    vec_t tbl [42];

    initial begin
        idle_v = mk(0,0,0,16'h0,24'h0,0,0,16'h0,0,0,0,24'h0);
        drive(idle_v);
        rst = 1'b1;
        tick(); tick();
        check("reset busy",  {31'd0, fb_busy},    32'd0);
        check("reset valid", {31'd0, disp_valid}, 32'd0);
        check("reset data",  {8'd0, rgb_out()},   32'd0);

`ifndef FB_AUTOCLEAR_EN
        //          rst wfb dfb px       colour     vs req rpx       busy val chk data
        tbl[0]  = mk(0, 1, 0, 16'h0305, 24'hAAAAAA, 0, 0, 16'h0000, 0, 0, 1, 24'h000000);
        tbl[1]  = mk(0, 1, 0, 16'h0000, 24'h555555, 0, 0, 16'h0000, 0, 0, 0, 24'h0);
        tbl[2]  = mk(0, 0, 1, 16'h0000, 24'h0,      0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[3]  = mk(0, 0, 0, 16'h0000, 24'h0,      1, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[4]  = mk(0, 0, 0, 16'h0000, 24'h0,      0, 1, 16'h0305, 0, 1, 1, 24'hAAAAAA);
        tbl[5]  = mk(0, 1, 0, 16'h0305, 24'h010203, 0, 0, 16'h0000, 0, 0, 1, 24'hAAAAAA);
        tbl[6]  = mk(0, 1, 0, 16'h0000, 24'h040506, 0, 0, 16'h0000, 0, 0, 0, 24'h0);
        // write 0x112233 to (5,3) and read the front copy in the same cycle
        tbl[7]  = mk(0, 1, 0, 16'h0305, 24'h112233, 0, 1, 16'h0305, 0, 1, 1, 24'hAAAAAA);
        // swap request with a same-cycle write; vsync 10 cycles later
        tbl[8]  = mk(0, 1, 1, 16'h0000, 24'h778899, 0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[9]  = mk(0, 0, 0, 16'h0000, 24'h0,      0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[10] = mk(0, 1, 0, 16'h0000, 24'hFFFFFF, 0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[11] = mk(0, 0, 0, 16'h0000, 24'h0,      0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[12] = mk(0, 0, 1, 16'h0000, 24'h0,      0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[13] = mk(0, 0, 0, 16'h0000, 24'h0,      0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[14] = mk(0, 0, 0, 16'h0000, 24'h0,      0, 1, 16'h0305, 1, 1, 1, 24'hAAAAAA);
        tbl[15] = mk(0, 0, 0, 16'h0000, 24'h0,      0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[16] = mk(0, 0, 0, 16'h0000, 24'h0,      0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[17] = mk(0, 0, 0, 16'h0000, 24'h0,      0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[18] = mk(0, 0, 0, 16'h0000, 24'h0,      1, 1, 16'h0000, 1, 1, 1, 24'h555555);
        // busy still high here: write and dfb are dropped
        tbl[19] = mk(0, 1, 1, 16'h0305, 24'hDEADBE, 0, 1, 16'h0305, 0, 1, 1, 24'h112233);
        tbl[20] = mk(0, 0, 0, 16'h0000, 24'h0,      0, 1, 16'h0000, 0, 1, 1, 24'h778899);
        tbl[21] = mk(0, 0, 1, 16'h0000, 24'h0,      0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[22] = mk(0, 0, 0, 16'h0000, 24'h0,      1, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[23] = mk(0, 0, 0, 16'h0000, 24'h0,      0, 1, 16'h0000, 0, 1, 1, 24'h555555);
        tbl[24] = mk(0, 0, 0, 16'h0000, 24'h0,      0, 1, 16'h0305, 0, 1, 1, 24'hAAAAAA);
        // dfb and vsync together: no swap until the next vsync
        tbl[25] = mk(0, 0, 1, 16'h0000, 24'h0,      1, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[26] = mk(0, 0, 0, 16'h0000, 24'h0,      0, 1, 16'h0305, 1, 1, 1, 24'hAAAAAA);
        tbl[27] = mk(0, 0, 0, 16'h0000, 24'h0,      1, 0, 16'h0000, 1, 0, 1, 24'hAAAAAA);
        tbl[28] = mk(0, 0, 0, 16'h0000, 24'h0,      0, 1, 16'h0305, 0, 1, 1, 24'h112233);
        tbl[29] = mk(0, 0, 1, 16'h0000, 24'h0,      0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[30] = mk(0, 0, 0, 16'h0000, 24'h0,      1, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[31] = mk(0, 0, 0, 16'h0000, 24'h0,      0, 0, 16'h0000, 0, 0, 0, 24'h0);
        // reset during SWAP_PEND with front bank 1
        tbl[32] = mk(0, 0, 1, 16'h0000, 24'h0,      0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[33] = mk(1, 0, 0, 16'h0000, 24'h0,      0, 0, 16'h0000, 0, 0, 1, 24'h000000);
        tbl[34] = mk(0, 1, 0, 16'h0000, 24'h0A0B0C, 0, 1, 16'h0000, 0, 1, 1, 24'h778899);
        tbl[35] = mk(0, 0, 1, 16'h0000, 24'h0,      0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[36] = mk(0, 0, 0, 16'h0000, 24'h0,      1, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[37] = mk(0, 0, 0, 16'h0000, 24'h0,      0, 1, 16'h0000, 0, 1, 1, 24'h0A0B0C);
        // top-right/bottom corner address
        tbl[38] = mk(0, 1, 0, 16'hFFFF, 24'h123456, 0, 0, 16'h0000, 0, 0, 0, 24'h0);
        tbl[39] = mk(0, 0, 1, 16'h0000, 24'h0,      0, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[40] = mk(0, 0, 0, 16'h0000, 24'h0,      1, 0, 16'h0000, 1, 0, 0, 24'h0);
        tbl[41] = mk(0, 0, 0, 16'h0000, 24'h0,      0, 1, 16'hFFFF, 0, 1, 1, 24'h123456);

        drive(idle_v);
        tick();
        for (int i = 0; i < 42; i++) begin
            drive(tbl[i]);
            tick();
            check($sformatf("row%0d busy", i),  {31'd0, fb_busy},    {31'd0, tbl[i].e_busy});
            check($sformatf("row%0d valid", i), {31'd0, disp_valid}, {31'd0, tbl[i].e_valid});
            if (tbl[i].chk)
                check($sformatf("row%0d data", i), {8'd0, rgb_out()}, {8'd0, tbl[i].e_data});
        end
`else
        begin
            vec_t v;
            int   hi;
            drive(idle_v);
            tick();
            // back bank 1 gets a marker, then swap into CLEAR of bank 0
            v = idle_v; v.wfb = 1; v.px = 16'h0305; v.col = 24'h112233;
            drive(v); tick();
            v = idle_v; v.dfb = 1; drive(v); tick();
            check("clr dfb busy", {31'd0, fb_busy}, 32'd1);
            v = idle_v; v.vsync = 1; drive(v); tick();
            check("clr swap busy", {31'd0, fb_busy}, 32'd1);
            // front read works while clearing
            v = idle_v; v.req = 1; v.rpx = 16'h0305; drive(v); tick();
            check("clr front data", {8'd0, rgb_out()}, 32'h00112233);
            check("clr front valid", {31'd0, disp_valid}, 32'd1);
            drive(idle_v);
            hi = 0;
            for (int k = 0; k < 70000; k++) begin
                if (!fb_busy) break;
                hi++;
                tick();
            end
            check("clr busy cycles", hi, 32'd65536);
            // dirty the cleared bank at one pixel, then swap it to the front
            v = idle_v; v.wfb = 1; v.px = 16'h0305; v.col = 24'hDEADBE;
            drive(v); tick();
            v = idle_v; v.dfb = 1; drive(v); tick();
            v = idle_v; v.vsync = 1; drive(v); tick();
            v = idle_v; v.req = 1; v.rpx = 16'h0305; drive(v); tick();
            check("clr dirty px", {8'd0, rgb_out()}, 32'h00DEADBE);
            v.rpx = 16'h0000; drive(v); tick();
            check("clr px0000", {8'd0, rgb_out()}, 32'd0);
            v.rpx = 16'h1234; drive(v); tick();
            check("clr px1234", {8'd0, rgb_out()}, 32'd0);
            v.rpx = 16'hFFFF; drive(v); tick();
            check("clr pxFFFF", {8'd0, rgb_out()}, 32'd0);
            // abort the second clear
            v = idle_v; v.rst = 1; drive(v); tick();
            check("clr rst busy",  {31'd0, fb_busy},    32'd0);
            check("clr rst valid", {31'd0, disp_valid}, 32'd0);
            v = idle_v; v.req = 1; v.rpx = 16'h0305; drive(v); tick();
            check("clr rst front", {8'd0, rgb_out()}, 32'h00DEADBE);
        end
`endif

        drive(idle_v);
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
